tlb_multiport: RTL
==================

# tlb_multiport

Parametrised MIPS-style joint TLB with N independent translation ports and one management port, succeeding the fixed two-port 32-entry TLB. Sits between the CP0/pipeline and the instruction/data caches. It translates kuseg/kseg2/kseg3 through a fully associative dual-page entry array and kseg0/kseg1 by fixed mapping. It executes TLBP/TLBR/TLBWI/TLBWR and maintains the Random register internally.

## Interface
- `ENTRIES`, 32, number of TLB entries; power of two, 4..64.
- `PORTS`, 2, number of lookup ports; port 0 is instruction fetch, the rest are data.
- `IDX_W`, $clog2(ENTRIES), index width (derived).

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `asid`  in  8  current EntryHi.ASID, shared by all ports.
- `lk_valid`  in  [PORTS]  lookup request, one per port.
- `lk_vaddr`  in  [PORTS][32]  virtual address.
- `lk_wr`  in  [PORTS]  request is a store.
- `lk_done`  out  [PORTS]  result valid; asserted one cycle after `lk_valid`.
- `lk_paddr`  out  [PORTS][32]  physical address.
- `lk_uncached`  out  [PORTS]  1 for kseg1, or when the selected C field equals 2.
- `lk_exc`  out  [PORTS] tlb_exc_t  NONE, REFILL_L, REFILL_S, INVALID_L, INVALID_S or MODIFIED.
- `op_valid`  in  1  management request strobe.
- `op`  in  tlb_req_t  TLBP, TLBR, TLBWI or TLBWR.
- `op_info`  in  tlb_t  index, entryhi, entrylo0 and entrylo1 from CP0.
- `wired`  in  IDX_W  CP0 Wired.
- `op_done`  out  1  one-cycle pulse.
- `op_res`  out  tlb_t  TLBP/TLBR result.
- `random`  out  IDX_W  current Random value.

## Operation
- Entry fields: VPN2[18:0], ASID[7:0], G, and {PFN[19:0], C[2:0], D, V} for each of the two pages.
- Reset state:
  - every entry has V0=V1=D0=D1=G=0 and VPN2=0;
  - `random`=ENTRIES-1;
  - all `lk_done`, `lk_exc`=NONE, `lk_paddr`=0, `op_done`=0 and `op_res`=0.
- Segment decode uses vaddr[31:29]:
  - 100 (kseg0): paddr = vaddr & 0x1FFF_FFFF, cached, exc NONE.
  - 101 (kseg1): same mask, uncached, exc NONE.
  - All other segments are mapped.
- Mapped lookup:
  - Hit on entry i when VPN2[i]==vaddr[31:13] and (G[i] or ASID[i]==asid).
  - vaddr[12] selects page 0 or 1.
  - paddr = {PFN, vaddr[11:0]}.
- Multiple hits: the lowest index wins (software-undefined case; deterministic here).
- Exception priority:
  - no hit → REFILL_S if wr, else REFILL_L;
  - V=0 → INVALID_S / INVALID_L;
  - wr and D=0 → MODIFIED;
  - otherwise NONE.
- Ports are fully independent; all PORTS lookups complete every cycle with no stalls.
- TLBP: searches with op_info.entryhi VPN2/ASID.
  - Hit: op_res.index = {1'b0, hit index}.
  - Miss: bit31 = 1, low bits 0.
- TLBR: op_res.entryhi = {VPN2, 5'b0, ASID}; op_res.entrylo0/1 = {6'b0, PFN, C, D, V, G}; pagemask 0.
- TLBWI writes entry op_info.index[IDX_W-1:0]; TLBWR writes entry `random`.
  - G is written as entrylo0[0] & entrylo1[0].
  - PFN = entrylo[25:6], C = [5:3], D = [2], V = [1].
- Out-of-range index (bits above IDX_W nonzero) on TLBR/TLBWI: no write, op_res=0, op_done still pulses.
- Random:
  - decrements every cycle;
  - when it equals `wired`, or `wired` ≥ ENTRIES, the next value is ENTRIES-1;
  - a TLBWR does not pause it.

## Timing
- Lookup latency is 1 cycle. Inputs are sampled at edge k; `lk_done`/`lk_paddr`/`lk_exc` are valid after edge k and remain until the next edge. `lk_done` = registered `lk_valid`.
- Management latency is 1 cycle. op_done pulses exactly once per accepted `op_valid`. Back-to-back ops are allowed every cycle.
- Write/lookup collision:
  - A TLBWI/TLBWR at edge k updates the array at edge k.
  - Lookups sampled at edge k see the old contents.
  - Lookups sampled at edge k+1 see the new contents.
  - TLBP/TLBR follow the same rule.
- `op_valid` and `lk_valid` in the same cycle are both serviced; no arbitration.
- `rst` asserted mid-operation takes effect at the next edge. It clears all pending `lk_done`/`op_done`, and no write occurs on that edge even if `op_valid`=1.

## Structure
- Shared package `tlb_pkg` holds:
  - `tlb_t`, `tlb_req_t` and `tlb_exc_t`;
  - segment constants KSEG0=3'b100 and KSEG1=3'b101;
  - the UNCACHED C code constant = 2.
- Sub-module `tlb_match`: combinational match over all entries for one {vpn2, asid} query. It returns hit, lowest index, and the selected page fields.
  - Instantiated PORTS+1 times: one per lookup port plus one for TLBP.
- Entry array and Random counter live in the top module.

## Test plan
- Reset, then lookup vaddr 0x8000_1234 and 0xA000_1234 on port 0 → after 1 cycle paddr 0x0000_1234 both; uncached 0 then 1; exc NONE.
- Reset, then lookup 0x0040_0000 with wr=0 → REFILL_L. With wr=1 → REFILL_S.
- TLBWI idx 3 with entryhi 0x0040_0005, entrylo0 {PFN 0x12345, C 3, D 0, V 1, G 0}; lookup vaddr 0x0040_0ABC, asid 5:
  - load → paddr 0x12345ABC, NONE;
  - store → MODIFIED;
  - asid 6 → REFILL_L.
- Same-cycle TLBWI and lookup of the written VPN → first lookup REFILL_L, following cycle hit.
- TLBP on a present entry → index 3, bit31=0. TLBP on an absent entry → 0x8000_0000. TLBR idx 3 → entrylo0 returned as written.
- Random with ENTRIES=8 and wired=2 → sequence 7,6,5,4,3,2,7,…; TLBWR twice, 1 cycle apart → two distinct consecutive entries written.

Source files
------------

// File: rtl/tlb_multiport_pkg.sv
// Shared types for the multiport joint TLB.
// Request/exception codes, CP0 bundle and entry layout.
package tlb_pkg;

  localparam logic [2:0] KSEG0    = 3'b100;
  localparam logic [2:0] KSEG1    = 3'b101;
  localparam logic [2:0] UNCACHED = 3'd2;

  typedef enum logic [1:0] {
    TLBP,
    TLBR,
    TLBWI,
    TLBWR
  } tlb_req_t;

  typedef enum logic [2:0] {
    EXC_NONE,
    REFILL_L,
    REFILL_S,
    INVALID_L,
    INVALID_S,
    MODIFIED
  } tlb_exc_t;

  typedef struct packed {
    logic [31:0] index;
    logic [31:0] entryhi;
    logic [31:0] entrylo0;
    logic [31:0] entrylo1;
  } tlb_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    tlb_page_t   p0;
    tlb_page_t   p1;
  } tlb_entry_t;

  // EntryLo {PFN,C,D,V} occupies bits 25:1
  function automatic tlb_page_t lo2page(
    input logic [31:0] lo
  );
    return tlb_page_t'(lo[25:1]);
  endfunction

  function automatic logic [31:0] page2lo(
    input tlb_page_t p,
    input logic      g
  );
    return {6'b0, p, g};
  endfunction

endpackage

// File: rtl/tlb_multiport_if.sv
// Lookup and management bundle of the TLB.
// slave = TLB side, master = CP0/pipeline side.
interface tlb_multiport_if
  import tlb_pkg::*;
#(
  parameter int PORTS   = 2,
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
);
  logic [7:0]                  asid;
  logic [PORTS-1:0]            lk_valid;
  logic [PORTS-1:0][31:0]      lk_vaddr;
  logic [PORTS-1:0]            lk_wr;
  logic [PORTS-1:0]            lk_done;
  logic [PORTS-1:0][31:0]      lk_paddr;
  logic [PORTS-1:0]            lk_uncached;
  tlb_exc_t [PORTS-1:0]        lk_exc;
  logic                        op_valid;
  tlb_req_t                    op;
  tlb_t                        op_info;
  logic [IDX_W-1:0]            wired;
  logic                        op_done;
  tlb_t                        op_res;
  logic [IDX_W-1:0]            random;

  modport slave (
    input  asid, lk_valid, lk_vaddr, lk_wr,
    input  op_valid, op, op_info, wired,
    output lk_done, lk_paddr, lk_uncached, lk_exc,
    output op_done, op_res, random
  );

  modport master (
    output asid, lk_valid, lk_vaddr, lk_wr,
    output op_valid, op, op_info, wired,
    input  lk_done, lk_paddr, lk_uncached, lk_exc,
    input  op_done, op_res, random
  );
endinterface

// File: rtl/tlb_multiport_match.sv
// Fully associative match of one {vpn2,asid} query.
// Lowest matching index wins on multiple hits.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  tlb_entry_t [ENTRIES-1:0] ents,
  input  logic [18:0]              vpn2,
  input  logic [7:0]               asid,
  input  logic                     odd,
  output logic                     hit,
  output logic [IDX_W-1:0]         idx,
  output tlb_page_t                page
);

  // scan high to low so the lowest hit is kept last
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    page = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ents[i].vpn2 == vpn2 &&
          (ents[i].g || ents[i].asid == asid)) begin
        hit  = 1'b1;
        idx  = IDX_W'(i);
        page = odd ? ents[i].p1 : ents[i].p0;
      end
    end
  end

endmodule

// File: rtl/tlb_multiport.sv
// MIPS-style joint TLB: PORTS lookups per cycle,
// plus TLBP/TLBR/TLBWI/TLBWR and the Random register.
module tlb_multiport
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int PORTS   = 2,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input logic           clk,
  input logic           rst,
  tlb_multiport_if.slave bus
);

  tlb_entry_t [ENTRIES-1:0] ents;
  logic [IDX_W-1:0]         rnd;

  logic             hit_w [PORTS];
  logic [IDX_W-1:0] idx_w [PORTS];
  tlb_page_t        pg_w  [PORTS];

  logic [PORTS-1:0]       unm;
  logic [PORTS-1:0]       unc_d;
  logic [PORTS-1:0][31:0] paddr_d;
  tlb_exc_t [PORTS-1:0]   exc_d;

  logic [PORTS-1:0]       done_q;
  logic [PORTS-1:0]       unc_q;
  logic [PORTS-1:0][31:0] paddr_q;
  tlb_exc_t [PORTS-1:0]   exc_q;

  logic             p_hit;
  logic [IDX_W-1:0] p_idx;
  tlb_page_t        p_pg;

  logic             oor;
  logic             we;
  logic [IDX_W-1:0] wr_idx;
  tlb_entry_t       new_ent;
  tlb_entry_t       rd;
  tlb_t             res_d;
  logic             op_done_q;
  tlb_t             op_res_q;

  genvar p;
  generate
    for (p = 0; p < PORTS; p++) begin : g_lk
      tlb_match #(
        .ENTRIES(ENTRIES),
        .IDX_W  (IDX_W)
      ) u_match (
        .ents(ents),
        .vpn2(bus.lk_vaddr[p][31:13]),
        .asid(bus.asid),
        .odd (bus.lk_vaddr[p][12]),
        .hit (hit_w[p]),
        .idx (idx_w[p]),
        .page(pg_w[p])
      );
    end
  endgenerate

  tlb_match #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W)
  ) u_probe (
    .ents(ents),
    .vpn2(bus.op_info.entryhi[31:13]),
    .asid(bus.op_info.entryhi[7:0]),
    .odd (1'b0),
    .hit (p_hit),
    .idx (p_idx),
    .page(p_pg)
  );

  // per-port translation and exception priority
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      unm[i] = bus.lk_vaddr[i][31:29] == KSEG0 ||
               bus.lk_vaddr[i][31:29] == KSEG1;
      unc_d[i] = bus.lk_vaddr[i][31:29] == KSEG1 ||
                 (!unm[i] && hit_w[i] &&
                  pg_w[i].c == UNCACHED);
      if (unm[i])
        paddr_d[i] = {3'b0, bus.lk_vaddr[i][28:0]};
      else if (hit_w[i])
        paddr_d[i] = {pg_w[i].pfn, bus.lk_vaddr[i][11:0]};
      else
        paddr_d[i] = '0;
      exc_d[i] = EXC_NONE;
      if (!unm[i]) begin
        if (!hit_w[i])
          exc_d[i] = bus.lk_wr[i] ? REFILL_S : REFILL_L;
        else if (!pg_w[i].v)
          exc_d[i] = bus.lk_wr[i] ? INVALID_S : INVALID_L;
        else if (bus.lk_wr[i] && !pg_w[i].d)
          exc_d[i] = MODIFIED;
      end
    end
  end

  // register lookup results
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= '0;
      unc_q   <= '0;
      paddr_q <= '0;
      exc_q   <= {PORTS{EXC_NONE}};
    end else begin
      done_q  <= bus.lk_valid;
      unc_q   <= unc_d;
      paddr_q <= paddr_d;
      exc_q   <= exc_d;
    end
  end

  assign oor     = |bus.op_info.index[31:IDX_W];
  assign wr_idx  = (bus.op == TLBWR) ? rnd
                 : bus.op_info.index[IDX_W-1:0];
  assign we      = bus.op_valid &&
                   (bus.op == TLBWR ||
                    (bus.op == TLBWI && !oor));
  assign rd      = ents[bus.op_info.index[IDX_W-1:0]];

  assign new_ent.vpn2 = bus.op_info.entryhi[31:13];
  assign new_ent.asid = bus.op_info.entryhi[7:0];
  assign new_ent.g    = bus.op_info.entrylo0[0] &
                        bus.op_info.entrylo1[0];
  assign new_ent.p0   = lo2page(bus.op_info.entrylo0);
  assign new_ent.p1   = lo2page(bus.op_info.entrylo1);

  // TLBP/TLBR result, zero for writes and bad index
  always_comb begin
    res_d = '0;
    unique case (1'b1)
      bus.op == TLBP: begin
        res_d.index = p_hit ? 32'(p_idx)
                            : 32'h8000_0000;
      end
      bus.op == TLBR && !oor: begin
        res_d.entryhi  = {rd.vpn2, 5'b0, rd.asid};
        res_d.entrylo0 = page2lo(rd.p0, rd.g);
        res_d.entrylo1 = page2lo(rd.p1, rd.g);
      end
      default: ;
    endcase
  end

  // management completion and result
  always_ff @(posedge clk) begin
    if (rst) begin
      op_done_q <= 1'b0;
      op_res_q  <= '0;
    end else begin
      op_done_q <= bus.op_valid;
      if (bus.op_valid)
        op_res_q <= res_d;
    end
  end

  // entry array; writes land at the sampling edge
  always_ff @(posedge clk) begin
    if (rst)
      ents <= '0;
    else if (we)
      ents[wr_idx] <= new_ent;
  end

  // Random free-runs down to Wired, then wraps
  always_ff @(posedge clk) begin
    if (rst)
      rnd <= IDX_W'(ENTRIES - 1);
    else if (rnd == bus.wired ||
             int'(bus.wired) >= ENTRIES)
      rnd <= IDX_W'(ENTRIES - 1);
    else
      rnd <= rnd - 1'b1;
  end

  assign bus.lk_done     = done_q;
  assign bus.lk_uncached = unc_q;
  assign bus.lk_paddr    = paddr_q;
  assign bus.lk_exc      = exc_q;
  assign bus.op_done     = op_done_q;
  assign bus.op_res      = op_res_q;
  assign bus.random      = rnd;

endmodule
